// File: rtl/lut_pkg.sv
// Shared types and constants for the VC lookup table and its access arbiter.
// Contents:
//   LUT_ASIZE / LUT_DW  table index width and entry width (256 x 20)
//   lut_entry_t         one table entry
//   lut_idx_t           one table index
//   rr_wrap()           round-robin pointer advance: (idx + 1) mod n
package lut_pkg;

  localparam int LUT_ASIZE = 8;
  localparam int LUT_DW    = 20;

  typedef logic [LUT_DW-1:0]    lut_entry_t;
  typedef logic [LUT_ASIZE-1:0] lut_idx_t;

  // Next round-robin start position after granting idx among n requesters.
  function automatic int unsigned rr_wrap(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/lut_access_arbiter_rr_arbiter.sv
// Round-robin arbiter, purely combinational.
// Picks the first set bit of req_i searching upward from ptr_i and wrapping
// from N-1 back to 0.
// Ports:
//   req_i        N   request vector
//   ptr_i        PW  search start position (highest priority this cycle)
//   gnt_o        N   one-hot grant (all zero when no request)
//   gnt_idx_o    PW  index of the granted bit (0 when no request)
//   gnt_valid_o  1   some request was granted
module rr_arbiter #(
  parameter int N  = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] gnt_idx_o,
  output logic          gnt_valid_o
);

  int idx;

  // Scan offsets from farthest to nearest so the nearest requester at or
  // after ptr_i is the last assignment and therefore wins.
  always_comb begin
    gnt_o       = '0;
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    idx         = 0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = (int'(ptr_i) + i) % N;
      if (req_i[idx]) begin
        gnt_o       = '0;
        gnt_o[idx]  = 1'b1;
        gnt_idx_o   = PW'(idx);
        gnt_valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lut_access_arbiter.sv
// Shares the VC lookup table between NPORT ingress lookup requesters and the
// host configuration write path. At most one access per cycle: a host write
// (priority, limited to HOST_BURST consecutive wins while lookups wait) or a
// round-robin forwarding read whose result is registered for one cycle.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   lk_req_i/lk_addr_i           per-port lookup request (level) and index
//   lk_gnt_o                     one-hot grant, same cycle as the table read
//   rsp_valid_o/rsp_data_o       one-hot response strobe and shared result
//   cfg_wr_req_i/addr/wdata      host write request (level) and payload
//   cfg_wr_ack_o                 host write accepted, same cycle as tbl_wren_o
//   tbl_wren_o/waddr/wdata       table host write port
//   tbl_rden_o/raddr/rdata_i     table forwarding read port (comb read)
module lut_access_arbiter
  import lut_pkg::*;
#(
  parameter int NPORT      = 4,
  parameter int ASIZE      = LUT_ASIZE,
  parameter int DW         = LUT_DW,
  parameter int HOST_BURST = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NPORT-1:0]       lk_req_i,
  input  logic [NPORT*ASIZE-1:0] lk_addr_i,
  output logic [NPORT-1:0]       lk_gnt_o,
  output logic [NPORT-1:0]       rsp_valid_o,
  output logic [DW-1:0]          rsp_data_o,
  input  logic                   cfg_wr_req_i,
  input  logic [ASIZE-1:0]       cfg_addr_i,
  input  logic [DW-1:0]          cfg_wdata_i,
  output logic                   cfg_wr_ack_o,
  output logic                   tbl_wren_o,
  output logic [ASIZE-1:0]       tbl_waddr_o,
  output logic [DW-1:0]          tbl_wdata_o,
  output logic                   tbl_rden_o,
  output logic [ASIZE-1:0]       tbl_raddr_o,
  input  logic [DW-1:0]          tbl_rdata_i
);

  localparam int PW = $clog2(NPORT);
  localparam int SW = $clog2(HOST_BURST + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(HOST_BURST);

  logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [SW-1:0]    streak_q, streak_d;
  logic [NPORT-1:0] rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]    rsp_data_q, rsp_data_d;

  logic [ASIZE-1:0] addr_arr [NPORT];
  logic [NPORT-1:0] arb_gnt;
  logic [PW-1:0]    arb_idx;
  logic             arb_valid;
  logic             host_win;
  logic             lk_win;

  for (genvar gi = 0; gi < NPORT; gi++) begin : g_addr
    assign addr_arr[gi] = lk_addr_i[gi*ASIZE +: ASIZE];
  end

  rr_arbiter #(.N(NPORT)) u_rr (
    .req_i       (lk_req_i),
    .ptr_i       (rr_ptr_q),
    .gnt_o       (arb_gnt),
    .gnt_idx_o   (arb_idx),
    .gnt_valid_o (arb_valid)
  );

  // Host yields only once it has used up its streak while a lookup waits.
  assign host_win = cfg_wr_req_i & ~(arb_valid & (streak_q == STREAK_MAX));
  assign lk_win   = arb_valid & ~host_win;

  always_comb begin
    lk_gnt_o     = '0;
    cfg_wr_ack_o = 1'b0;
    tbl_wren_o   = 1'b0;
    tbl_rden_o   = 1'b0;
    tbl_waddr_o  = cfg_addr_i;
    tbl_wdata_o  = cfg_wdata_i;
    tbl_raddr_o  = addr_arr[arb_idx];
    if (!rst_i) begin
      if (host_win) begin
        cfg_wr_ack_o = 1'b1;
        tbl_wren_o   = 1'b1;
      end else if (lk_win) begin
        lk_gnt_o   = arb_gnt;
        tbl_rden_o = 1'b1;
      end
    end
  end

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    streak_d    = streak_q;
    rsp_valid_d = lk_gnt_o;
    rsp_data_d  = rsp_data_q;
    if (lk_win) begin
      rr_ptr_d   = PW'(rr_wrap(32'(arb_idx), NPORT));
      rsp_data_d = tbl_rdata_i;
      streak_d   = '0;
    end else if (host_win) begin
      streak_d = (streak_q == STREAK_MAX) ? STREAK_MAX : streak_q + SW'(1);
    end else begin
      streak_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q    <= '0;
      streak_q    <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      streak_q    <= streak_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;

endmodule

// File: tb/tb_lut_access_arbiter.sv
// Directed bench for lut_access_arbiter with a behavioural 256x20 table
// (registered write, combinational read) attached to the table ports.
module tb_lut_access_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  lk_req;
  logic [31:0] lk_addr;
  logic [3:0]  lk_gnt;
  logic [3:0]  rsp_valid;
  logic [19:0] rsp_data;
  logic        cfg_wr_req;
  logic [7:0]  cfg_addr;
  logic [19:0] cfg_wdata;
  logic        cfg_wr_ack;
  logic        tbl_wren;
  logic [7:0]  tbl_waddr;
  logic [19:0] tbl_wdata;
  logic        tbl_rden;
  logic [7:0]  tbl_raddr;
  logic [19:0] tbl_rdata;

  logic [19:0] mem [256];

  int pass_cnt;
  int fail_cnt;
  int total;

  lut_access_arbiter #(
    .NPORT(4), .ASIZE(8), .DW(20), .HOST_BURST(4)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .lk_req_i     (lk_req),
    .lk_addr_i    (lk_addr),
    .lk_gnt_o     (lk_gnt),
    .rsp_valid_o  (rsp_valid),
    .rsp_data_o   (rsp_data),
    .cfg_wr_req_i (cfg_wr_req),
    .cfg_addr_i   (cfg_addr),
    .cfg_wdata_i  (cfg_wdata),
    .cfg_wr_ack_o (cfg_wr_ack),
    .tbl_wren_o   (tbl_wren),
    .tbl_waddr_o  (tbl_waddr),
    .tbl_wdata_o  (tbl_wdata),
    .tbl_rden_o   (tbl_rden),
    .tbl_raddr_o  (tbl_raddr),
    .tbl_rdata_i  (tbl_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (tbl_wren) mem[tbl_waddr] <= tbl_wdata;
  end
  assign tbl_rdata = mem[tbl_raddr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic log_cycle(input string tag);
    $display("[%0t] %s req=%b gnt=%b ack=%b rsp_valid=%b rsp_data=%05h",
             $time, tag, lk_req, lk_gnt, cfg_wr_ack, rsp_valid, rsp_data);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int k, input logic [7:0] a);
    lk_addr[k*8 +: 8] = a;
  endtask

  initial begin
    pass_cnt = 0;
    fail_cnt = 0;
    total    = 0;

    // Reset with every request asserted
    rst        = 1'b1;
    lk_req     = 4'hF;
    lk_addr    = {8'h03, 8'h02, 8'h01, 8'h00};
    cfg_wr_req = 1'b1;
    cfg_addr   = 8'h55;
    cfg_wdata  = 20'h0;
    next_cycle();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      log_cycle("reset");
      chk("rst_lk_gnt", 32'(lk_gnt), 32'h0);
      chk("rst_ack", 32'(cfg_wr_ack), 32'h0);
      chk("rst_wren", 32'(tbl_wren), 32'h0);
      chk("rst_rden", 32'(tbl_rden), 32'h0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_rsp_data", 32'(rsp_data), 32'h0);
      next_cycle();
    end

    // Round robin with all ports requesting straight out of reset
    rst        = 1'b0;
    cfg_wr_req = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      log_cycle("rr");
      chk("rr_gnt", 32'(lk_gnt), 32'(1 << (c % 4)));
      if (c > 0) chk("rr_rsp_valid", 32'(rsp_valid), 32'(1 << ((c - 1) % 4)));
      next_cycle();
    end
    lk_req = 4'h0;

    // Single lookup: first load table[0x2A] through the host path
    cfg_wr_req = 1'b1;
    cfg_addr   = 8'h2A;
    cfg_wdata  = 20'hABCDE;
    @(negedge clk);
    log_cycle("wr 2A");
    chk("wr_ack", 32'(cfg_wr_ack), 32'h1);
    chk("wr_wren", 32'(tbl_wren), 32'h1);
    chk("wr_waddr", 32'(tbl_waddr), 32'h2A);
    chk("wr_wdata", 32'(tbl_wdata), 32'hABCDE);
    chk("wr_lk_gnt", 32'(lk_gnt), 32'h0);
    chk("wr_rsp_valid_last_rr", 32'(rsp_valid), 32'h2);
    next_cycle();
    cfg_wr_req = 1'b0;
    lk_req     = 4'b0100;
    set_addr(2, 8'h2A);
    @(negedge clk);
    log_cycle("lookup p2");
    chk("single_gnt", 32'(lk_gnt), 32'h4);
    chk("single_rden", 32'(tbl_rden), 32'h1);
    chk("single_raddr", 32'(tbl_raddr), 32'h2A);
    chk("single_ack", 32'(cfg_wr_ack), 32'h0);
    next_cycle();
    lk_req = 4'h0;
    @(negedge clk);
    log_cycle("resp p2");
    chk("single_rsp_valid", 32'(rsp_valid), 32'h4);
    chk("single_rsp_data", 32'(rsp_data), 32'hABCDE);
    chk("single_gnt_after", 32'(lk_gnt), 32'h0);

    // Coherency: write 0x10, look it up the very next cycle
    next_cycle();
    cfg_wr_req = 1'b1;
    cfg_addr   = 8'h10;
    cfg_wdata  = 20'h12345;
    @(negedge clk);
    log_cycle("wr 10");
    chk("coh_ack", 32'(cfg_wr_ack), 32'h1);
    next_cycle();
    cfg_wr_req = 1'b0;
    lk_req     = 4'b0001;
    set_addr(0, 8'h10);
    @(negedge clk);
    log_cycle("lookup p0");
    chk("coh_gnt", 32'(lk_gnt), 32'h1);
    chk("coh_raddr", 32'(tbl_raddr), 32'h10);
    next_cycle();
    lk_req = 4'h0;
    @(negedge clk);
    log_cycle("resp p0");
    chk("coh_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("coh_rsp_data", 32'(rsp_data), 32'h12345);

    // Starvation guard: 10 host writes while port1 waits
    next_cycle();
    begin
      int w;
      w          = 0;
      cfg_wr_req = 1'b1;
      lk_req     = 4'b0010;
      set_addr(1, 8'h2A);
      for (int c = 1; c <= 11; c++) begin
        cfg_addr  = 8'h80 + 8'(w);
        cfg_wdata = 20'h01000 + 20'(w * 20'h111);
        @(negedge clk);
        log_cycle("starve");
        chk("starve_gnt", 32'(lk_gnt), (c == 5) ? 32'h2 : 32'h0);
        chk("starve_ack", 32'(cfg_wr_ack), (c == 5) ? 32'h0 : 32'h1);
        if (c != 5) chk("starve_wdata", 32'(tbl_wdata), 32'h01000 + 32'(w * 32'h111));
        if (c == 6) begin
          chk("starve_rsp_valid", 32'(rsp_valid), 32'h2);
          chk("starve_rsp_data", 32'(rsp_data), 32'hABCDE);
        end
        next_cycle();
        if (c == 5) lk_req = 4'h0;
        else w++;
      end
      chk("starve_writes", 32'(w), 32'd10);
    end
    cfg_wr_req = 1'b0;
    @(negedge clk);
    log_cycle("idle");
    chk("idle_ack", 32'(cfg_wr_ack), 32'h0);
    next_cycle();

    // Streak saturation: host keeps winning with no lookup pending,
    // then a lookup arriving at saturation wins immediately.
    cfg_wr_req = 1'b1;
    for (int c = 0; c < 6; c++) begin
      cfg_addr  = 8'hC0 + 8'(c);
      cfg_wdata = 20'h0C000 + 20'(c);
      @(negedge clk);
      log_cycle("sat wr");
      chk("sat_ack", 32'(cfg_wr_ack), 32'h1);
      next_cycle();
    end
    cfg_addr  = 8'hC6;
    cfg_wdata = 20'h0C006;
    lk_req    = 4'b1000;
    set_addr(3, 8'h85);
    @(negedge clk);
    log_cycle("sat lookup");
    chk("sat_gnt", 32'(lk_gnt), 32'h8);
    chk("sat_ack_yield", 32'(cfg_wr_ack), 32'h0);
    next_cycle();
    lk_req = 4'h0;
    @(negedge clk);
    log_cycle("sat resp");
    chk("sat_ack_resume", 32'(cfg_wr_ack), 32'h1);
    chk("sat_rsp_valid", 32'(rsp_valid), 32'h8);
    chk("sat_rsp_data", 32'(rsp_data), 32'h01555);
    next_cycle();
    cfg_wr_req = 1'b0;

    // Mid-operation reset right after a lookup grant
    lk_req = 4'b0100;
    set_addr(2, 8'h2A);
    @(negedge clk);
    log_cycle("pre-rst grant");
    chk("mrst_pre_gnt", 32'(lk_gnt), 32'h4);
    #1;
    rst = 1'b1;
    #1;
    chk("mrst_gnt_forced", 32'(lk_gnt), 32'h0);
    next_cycle();
    rst    = 1'b0;
    lk_req = 4'hF;
    @(negedge clk);
    log_cycle("post-rst");
    chk("mrst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("mrst_rsp_data", 32'(rsp_data), 32'h0);
    chk("mrst_gnt_p0", 32'(lk_gnt), 32'h1);
    next_cycle();
    lk_req = 4'b1110;
    @(negedge clk);
    log_cycle("post-rst 2");
    chk("mrst_gnt_p1", 32'(lk_gnt), 32'h2);
    chk("mrst_rsp_valid_p0", 32'(rsp_valid), 32'h1);
    next_cycle();
    lk_req = 4'h0;

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
